// File: rtl/alu_issue_sequencer.sv
// Multi-cycle issue sequencer for the gate-delay modelled 32-bit ripple ALU.
// Optional overflow trap on add/addi/sub is enabled by defining ALU_OVERFLOW_TRAP_EN.
module alu_issue_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int WIDTH         = 32
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] RsData,
    input  logic [WIDTH-1:0] RtData,
    input  logic [15:0]      Imm,
    output logic [WIDTH-1:0] BusA,
    output logic [WIDTH-1:0] BusB,
    output logic [1:0]       ALUControl,
    input  logic [WIDTH-1:0] AluOutput,
    input  logic             AluCarryOut,
    input  logic             AluZero,
    input  logic             AluOverflow,
    input  logic             AluNegative,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags,
    output logic             ResultWrite,
    output logic             BranchTaken,
    output logic             Illegal,
    output logic             OverflowTrap
);

    generate
        if (WIDTH != 32) begin : g_width_check
            $error("alu_issue_sequencer: WIDTH must be 32");
        end
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_check
            $error("alu_issue_sequencer: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_XOR = 2'b01,
        ALU_SUB = 2'b10,
        ALU_SLT = 2'b11
    } alu_op_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] busa_q, busa_d;
    logic [WIDTH-1:0] busb_q, busb_d;
    alu_op_e          ctrl_q, ctrl_d;
    logic             branch_q, branch_d;
    logic             bne_q, bne_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             rwrite_q, rwrite_d;
    logic             btaken_q, btaken_d;
    logic             illegal_q, illegal_d;

    logic             dec_legal;
    alu_op_e          dec_ctrl;
    logic [WIDTH-1:0] dec_busb;
    logic             dec_branch;
    logic             dec_bne;

    logic             accept;
    logic             capture;
    logic             trap_now;

    assign accept  = (state_q == IDLE) && InValid;
    assign capture = (state_q == SETTLE) && (cnt_q == SETTLE_LAST);

    always_comb begin
        dec_legal  = 1'b1;
        dec_ctrl   = ALU_ADD;
        dec_busb   = RtData;
        dec_branch = 1'b0;
        dec_bne    = 1'b0;
        case (Opcode)
            6'h00: begin
                case (Funct)
                    6'h20:   dec_ctrl = ALU_ADD;
                    6'h22:   dec_ctrl = ALU_SUB;
                    6'h26:   dec_ctrl = ALU_XOR;
                    6'h2A:   dec_ctrl = ALU_SLT;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08: begin
                dec_ctrl = ALU_ADD;
                dec_busb = {{(WIDTH-16){Imm[15]}}, Imm};
            end
            6'h0A: begin
                dec_ctrl = ALU_SLT;
                dec_busb = {{(WIDTH-16){Imm[15]}}, Imm};
            end
            6'h0E: begin
                dec_ctrl = ALU_XOR;
                dec_busb = {{(WIDTH-16){1'b0}}, Imm};
            end
            6'h04: begin
                dec_ctrl   = ALU_SUB;
                dec_branch = 1'b1;
            end
            6'h05: begin
                dec_ctrl   = ALU_SUB;
                dec_branch = 1'b1;
                dec_bne    = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

`ifdef ALU_OVERFLOW_TRAP_EN
    logic trapop_q;
    logic trap_q;
    logic dec_trapop;

    assign dec_trapop = ((Opcode == 6'h00) && ((Funct == 6'h20) || (Funct == 6'h22)))
                        || (Opcode == 6'h08);
    assign trap_now   = trapop_q & AluOverflow;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            trapop_q <= 1'b0;
            trap_q   <= 1'b0;
        end else if (accept) begin
            trapop_q <= dec_legal & dec_trapop;
            trap_q   <= 1'b0;
        end else if (capture) begin
            trap_q   <= trap_now;
        end
    end

    assign OverflowTrap = trap_q;
`else
    assign trap_now     = 1'b0;
    assign OverflowTrap = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busa_d    = busa_q;
        busb_d    = busb_q;
        ctrl_d    = ctrl_q;
        branch_d  = branch_q;
        bne_d     = bne_q;
        result_d  = result_q;
        flags_d   = flags_q;
        rwrite_d  = rwrite_q;
        btaken_d  = btaken_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_legal) begin
                        busa_d   = RsData;
                        busb_d   = dec_busb;
                        ctrl_d   = dec_ctrl;
                        branch_d = dec_branch;
                        bne_d    = dec_bne;
                        cnt_d    = 4'd1;
                        state_d  = SETTLE;
                    end else begin
                        // ALU drive registers stay untouched so the ALU is not disturbed
                        result_d  = '0;
                        flags_d   = '0;
                        rwrite_d  = 1'b0;
                        btaken_d  = 1'b0;
                        illegal_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            SETTLE: begin
                if (capture) begin
                    result_d  = branch_q ? '0 : AluOutput;
                    flags_d   = {AluNegative, AluOverflow, AluCarryOut, AluZero};
                    rwrite_d  = ~branch_q & ~trap_now;
                    btaken_d  = branch_q & (AluZero ^ bne_q);
                    illegal_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busa_q    <= '0;
            busb_q    <= '0;
            ctrl_q    <= ALU_ADD;
            branch_q  <= 1'b0;
            bne_q     <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            rwrite_q  <= 1'b0;
            btaken_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busa_q    <= busa_d;
            busb_q    <= busb_d;
            ctrl_q    <= ctrl_d;
            branch_q  <= branch_d;
            bne_q     <= bne_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            rwrite_q  <= rwrite_d;
            btaken_q  <= btaken_d;
            illegal_q <= illegal_d;
        end
    end

    assign InReady     = (state_q == IDLE);
    assign OutValid    = (state_q == DONE);
    assign BusA        = busa_q;
    assign BusB        = busb_q;
    assign ALUControl  = ctrl_q;
    assign Result      = result_q;
    assign Flags       = flags_q;
    assign ResultWrite = rwrite_q;
    assign BranchTaken = btaken_q;
    assign Illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: behavioural ALU with settle modelling, vector table and scoreboard.
module tb_alu_issue_sequencer;

    localparam int S = 4;
`ifdef ALU_OVERFLOW_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [5:0]  Opcode = '0;
    logic [5:0]  Funct = '0;
    logic [31:0] RsData = '0;
    logic [31:0] RtData = '0;
    logic [15:0] Imm = '0;
    logic [31:0] BusA, BusB;
    logic [1:0]  ALUControl;
    logic [31:0] AluOutput;
    logic        AluCarryOut, AluZero, AluOverflow, AluNegative;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] Result;
    logic [3:0]  Flags;
    logic        ResultWrite, BranchTaken, Illegal, OverflowTrap;

    alu_issue_sequencer #(.SETTLE_CYCLES(S), .WIDTH(32)) dut (
        .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .Opcode(Opcode), .Funct(Funct), .RsData(RsData), .RtData(RtData), .Imm(Imm),
        .BusA(BusA), .BusB(BusB), .ALUControl(ALUControl),
        .AluOutput(AluOutput), .AluCarryOut(AluCarryOut), .AluZero(AluZero),
        .AluOverflow(AluOverflow), .AluNegative(AluNegative),
        .OutValid(OutValid), .OutReady(OutReady), .Result(Result), .Flags(Flags),
        .ResultWrite(ResultWrite), .BranchTaken(BranchTaken), .Illegal(Illegal),
        .OverflowTrap(OverflowTrap)
    );

    always #5 Clock = ~Clock;

    // Behavioural ALU: outputs are garbage until the buses have been stable long enough.
    logic [32:0] alu_s;
    logic [31:0] alu_r;
    logic        alu_c, alu_v;
    always_comb begin
        alu_s = '0;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (ALUControl)
            2'b00: begin
                alu_s = {1'b0, BusA} + {1'b0, BusB};
                alu_r = alu_s[31:0];
                alu_c = alu_s[32];
                alu_v = (BusA[31] == BusB[31]) && (alu_s[31] != BusA[31]);
            end
            2'b01: alu_r = BusA ^ BusB;
            default: begin
                alu_s = {1'b0, BusA} + {1'b0, ~BusB} + 33'd1;
                alu_c = alu_s[32];
                alu_v = (BusA[31] != BusB[31]) && (alu_s[31] != BusA[31]);
                alu_r = (ALUControl == 2'b11) ? {31'd0, ($signed(BusA) < $signed(BusB))} : alu_s[31:0];
            end
        endcase
    end

    logic [31:0] prev_a = '0, prev_b = '0;
    logic [1:0]  prev_c = '0;
    int          age = 1000;
    always @(negedge Clock) begin
        if (BusA !== prev_a || BusB !== prev_b || ALUControl !== prev_c) begin
            age    <= 0;
            prev_a <= BusA;
            prev_b <= BusB;
            prev_c <= ALUControl;
        end else if (age < 1000) begin
            age <= age + 1;
        end
    end
    logic settled;
    assign settled     = (age >= S - 1);
    assign AluOutput   = settled ? alu_r : 32'hDEADBEEF;
    assign AluNegative = settled ? alu_r[31] : 1'b1;
    assign AluOverflow = settled ? alu_v : 1'b1;
    assign AluCarryOut = settled ? alu_c : 1'b1;
    assign AluZero     = settled ? (alu_r == 32'd0) : 1'b1;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [1:0]  ctrl;
        logic [31:0] busb;
        logic [31:0] result;
        logic [3:0]  flags;
        logic        rw;
        logic        bt;
        logic        ill;
        logic        trap;
        int          hold;
    } vec_t;

    vec_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_a = '0, last_b = '0;
    logic [1:0]  last_c = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input vec_t e);
        chk({e.name, " OutValid"},     32'(OutValid), 32'd1);
        chk({e.name, " Result"},       Result, e.result);
        chk({e.name, " Flags"},        32'(Flags), 32'(e.flags));
        chk({e.name, " ResultWrite"},  32'(ResultWrite), 32'(e.rw));
        chk({e.name, " BranchTaken"},  32'(BranchTaken), 32'(e.bt));
        chk({e.name, " Illegal"},      32'(Illegal), 32'(e.ill));
        chk({e.name, " OverflowTrap"}, 32'(OverflowTrap), 32'(e.trap));
        chk({e.name, " InReady busy"}, 32'(InReady), 32'd0);
    endtask

    task automatic run_op(input vec_t v);
        int   cyc;
        vec_t e;
        OutReady = (v.hold == 0);
        Opcode   = v.op;
        Funct    = v.fn;
        RsData   = v.rs;
        RtData   = v.rt;
        Imm      = v.imm;
        InValid  = 1'b1;
        chk({v.name, " InReady idle"}, 32'(InReady), 32'd1);
        sb.push_back(v);
        @(posedge Clock); #1;
        // InValid stays high with junk operands: must be ignored while busy
        Opcode = 6'($urandom);
        Funct  = 6'($urandom);
        RsData = $urandom;
        RtData = $urandom;
        Imm    = 16'($urandom);
        cyc = 1;
        while (!OutValid && cyc < 64) begin
            chk({v.name, " InReady settle"}, 32'(InReady), 32'd0);
            chk({v.name, " BusA"}, BusA, v.rs);
            chk({v.name, " BusB"}, BusB, v.busb);
            chk({v.name, " ALUControl"}, 32'(ALUControl), 32'(v.ctrl));
            @(posedge Clock); #1;
            cyc++;
        end
        chk({v.name, " latency"}, 32'(cyc), v.ill ? 32'd1 : 32'(S + 1));
        e = sb.pop_front();
        if (v.ill) begin
            chk({v.name, " BusA kept"}, BusA, last_a);
            chk({v.name, " BusB kept"}, BusB, last_b);
            chk({v.name, " ALUControl kept"}, 32'(ALUControl), 32'(last_c));
        end
        for (int h = 0; h < v.hold; h++) begin
            chk_out(e);
            @(posedge Clock); #1;
        end
        OutReady = 1'b1;
        chk_out(e);
        @(posedge Clock); #1;
        InValid  = 1'b0;
        OutReady = 1'b0;
        chk({v.name, " OutValid drop"}, 32'(OutValid), 32'd0);
        chk({v.name, " InReady back"}, 32'(InReady), 32'd1);
        if (!v.ill) begin
            last_a = v.rs;
            last_b = v.busb;
            last_c = v.ctrl;
        end
    endtask

    function automatic vec_t mk(input string name, input logic [5:0] op, input logic [5:0] fn,
                                input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                                input logic [1:0] ctrl, input logic [31:0] busb, input logic [31:0] result,
                                input logic [3:0] flags, input logic rw, input logic bt,
                                input logic ill, input logic trap, input int hold);
        vec_t v;
        v.name = name; v.op = op; v.fn = fn; v.rs = rs; v.rt = rt; v.imm = imm;
        v.ctrl = ctrl; v.busb = busb; v.result = result; v.flags = flags;
        v.rw = rw; v.bt = bt; v.ill = ill; v.trap = trap; v.hold = hold;
        return v;
    endfunction

    vec_t vecs[13];
    vec_t add11;

    initial begin
        //               name        op     fn     rs            rt            imm       ctrl   busb          result        NVCZ     rw    bt    ill   trap  hold
        vecs[0]  = mk("add",      6'h00, 6'h20, 32'd5,        32'd7,        16'h0000, 2'b00, 32'd7,        32'd12,       4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        vecs[1]  = mk("beq_t",    6'h04, 6'h00, 32'h1234,     32'h1234,     16'h0000, 2'b10, 32'h1234,     32'd0,        4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        vecs[2]  = mk("bne_t",    6'h05, 6'h00, 32'h1234,     32'h1235,     16'h0000, 2'b10, 32'h1235,     32'd0,        4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        vecs[3]  = mk("slti",     6'h0A, 6'h00, 32'hFFFFFFFE, 32'h0,        16'h0001, 2'b11, 32'd1,        32'd1,        4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        vecs[4]  = mk("xori",     6'h0E, 6'h00, 32'h0000FFFF, 32'h0,        16'h8000, 2'b01, 32'h00008000, 32'h00007FFF, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        vecs[5]  = mk("add_ovf",  6'h00, 6'h20, 32'h7FFFFFFF, 32'd1,        16'h0000, 2'b00, 32'd1,        32'h80000000, 4'b1100, !TRAP, 1'b0, 1'b0, TRAP, 0);
        vecs[6]  = mk("illegal",  6'h23, 6'h00, 32'h11,       32'h22,       16'h0033, 2'b00, 32'd0,        32'd0,        4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        vecs[7]  = mk("sub",      6'h00, 6'h22, 32'd10,       32'd3,        16'h0000, 2'b10, 32'd3,        32'd7,        4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        vecs[8]  = mk("slt",      6'h00, 6'h2A, 32'd3,        32'hFFFFFFFF, 16'h0000, 2'b11, 32'hFFFFFFFF, 32'd0,        4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        vecs[9]  = mk("beq_nt",   6'h04, 6'h00, 32'd1,        32'd2,        16'h0000, 2'b10, 32'd2,        32'd0,        4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        vecs[10] = mk("addi",     6'h08, 6'h00, 32'd10,       32'h0,        16'hFFFF, 2'b00, 32'hFFFFFFFF, 32'd9,        4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        vecs[11] = mk("ill_fn",   6'h00, 6'h21, 32'd4,        32'd4,        16'h0000, 2'b00, 32'd0,        32'd0,        4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        vecs[12] = mk("xor",      6'h00, 6'h26, 32'hF0F0F0F0, 32'hFFFFFFFF, 16'h0000, 2'b01, 32'hFFFFFFFF, 32'h0F0F0F0F, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        add11    = mk("add_1_1",  6'h00, 6'h20, 32'd1,        32'd1,        16'h0000, 2'b00, 32'd1,        32'd2,        4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        repeat (2) @(posedge Clock);
        #1;
        chk("reset InReady",     32'(InReady), 32'd1);
        chk("reset OutValid",    32'(OutValid), 32'd0);
        chk("reset BusA",        BusA, 32'd0);
        chk("reset BusB",        BusB, 32'd0);
        chk("reset ALUControl",  32'(ALUControl), 32'd0);
        chk("reset Result",      Result, 32'd0);
        chk("reset Flags",       32'(Flags), 32'd0);
        chk("reset outs",        {28'd0, ResultWrite, BranchTaken, Illegal, OverflowTrap}, 32'd0);
        ResetN = 1'b1;
        @(posedge Clock); #1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i]);
        end

        // Reset in the middle of a settle window abandons the operation
        Opcode  = 6'h00;
        Funct   = 6'h20;
        RsData  = 32'd5;
        RtData  = 32'd7;
        InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        @(posedge Clock); #1;
        chk("pre-reset busy", 32'(InReady), 32'd0);
        ResetN = 1'b0;
        #1;
        chk("midreset InReady",  32'(InReady), 32'd1);
        chk("midreset OutValid", 32'(OutValid), 32'd0);
        chk("midreset BusA",     BusA, 32'd0);
        #1;
        ResetN = 1'b1;
        last_a = '0;
        last_b = '0;
        last_c = '0;
        for (int c = 0; c < S + 3; c++) begin
            @(posedge Clock); #1;
            chk("postreset OutValid", 32'(OutValid), 32'd0);
        end
        run_op(add11);

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Multi-cycle initiator for the 32-bit ripple ALU. It is the producer of BusA/BusB/ALUControl and the consumer of Output/CarryOut/Zero/Overflow/Negative.
- Accepts one decoded MIPS ALU/branch instruction per handshake and drives registered operands and control to the ALU.
- Waits a fixed settle window, because the ALU is gate-delay modelled. It then captures result and flags and presents them downstream with a valid/ready handshake.
- Sits between the decode stage and the writeback/branch logic.

Parameters:
SETTLE_CYCLES, 4, clock cycles operands are held before capture; legal range 1..15
WIDTH, 32, datapath width; fixed at 32 (checked at elaboration)

Ports:
Clock  in  1  rising-edge clock
ResetN  in  1  asynchronous active-low reset
InValid  in  1  instruction offered
InReady  out  1  sequencer can accept (IDLE only)
Opcode  in  6  MIPS opcode
Funct  in  6  MIPS funct (used when Opcode=0)
RsData  in  32  rs operand
RtData  in  32  rt operand
Imm  in  16  immediate
BusA  out  32  to ALU BusA
BusB  out  32  to ALU BusB
ALUControl  out  2  to ALU: 00 add, 01 xor, 10 sub, 11 slt
AluOutput  in  32  from ALU Output
AluCarryOut, AluZero, AluOverflow, AluNegative  in  1 each  ALU flags
OutValid  out  1  result available
OutReady  in  1  downstream accepts
Result  out  32  captured ALU output (0 for branches/illegal)
Flags  out  4  {N, V, C, Z} captured
ResultWrite  out  1  result must be written to register file
BranchTaken  out  1  beq/bne decision
Illegal  out  1  unsupported opcode/funct
OverflowTrap  out  1  see Optional Feature

Behaviour:
- Reset (async, ResetN=0): state IDLE, SETTLE counter 0, all outputs 0 except InReady=1. Reset mid-operation abandons the op; no OutValid is produced.
- Decode, latched on accept (InValid & InReady):
  - R-type Funct 0x20 add -> 00, BusB=RtData
  - R-type Funct 0x22 sub -> 10, BusB=RtData
  - R-type Funct 0x26 xor -> 01, BusB=RtData
  - R-type Funct 0x2A slt -> 11, BusB=RtData
  - addi 0x08 -> 00; slti 0x0A -> 11; both with BusB=sign-extended Imm
  - xori 0x0E -> 01, BusB=zero-extended Imm
  - beq 0x04, bne 0x05 -> 10, BusB=RtData
  - BusA=RsData in all cases.
- Anything else is Illegal: BusA/BusB/ALUControl unchanged, no settle.
- States:
  - IDLE: InReady=1. Accept -> SETTLE for a legal op, -> DONE for an illegal op.
  - SETTLE: BusA/BusB/ALUControl driven from registers and stable. Counter runs 1..SETTLE_CYCLES. On the final count, capture AluOutput and flags, then -> DONE.
  - DONE: OutValid=1 and all result outputs stable until OutReady. On OutValid & OutReady -> IDLE, and OutValid drops the next cycle.
- Latency: accept at cycle 0 -> OutValid at cycle SETTLE_CYCLES+1 (legal) or cycle 1 (illegal). Throughput: one op per SETTLE_CYCLES+2 cycles minimum.
- InReady is 0 outside IDLE. There is no same-cycle accept on completion.
- Branches: BranchTaken = AluZero (beq) or ~AluZero (bne). ResultWrite=0, Result=0, Flags captured normally.
- Non-branch legal ops: ResultWrite=1, BranchTaken=0.
- Illegal: Illegal=1, Result=0, Flags=0, ResultWrite=0.
- OutReady held high on OutValid's first cycle completes immediately.
- InValid/operand changes while busy are ignored.

Optional Feature:
- Macro: ALU_OVERFLOW_TRAP_EN.
- When defined: for add/addi/sub, a captured AluOverflow=1 sets OverflowTrap=1 and forces ResultWrite=0; Result still holds the wrapped value.
- When not defined: OverflowTrap is tied 0 and overflow never affects ResultWrite.

Test Plan:
- add, RsData=5, RtData=7, SETTLE_CYCLES=4 -> ALUControl=00; OutValid at cycle 5; Result=12; Flags=0000; ResultWrite=1.
- beq, RsData=RtData=0x1234 -> ALUControl=10; Result=0; Flags Z=1; BranchTaken=1; ResultWrite=0. The same with RtData=0x1235 under bne -> BranchTaken=1.
- slti, RsData=0xFFFFFFFE, Imm=0x0001 -> BusB=0x00000001; Result=1. xori, Imm=0x8000 -> BusB=0x00008000.
- add, 0x7FFFFFFF+1 -> Result=0x80000000, V=1, N=1. With ALU_OVERFLOW_TRAP_EN: OverflowTrap=1, ResultWrite=0. Without: ResultWrite=1.
- Opcode=0x23 -> Illegal=1, OutValid at cycle 1. Hold OutReady=0 for 3 cycles -> outputs stable and InReady=0 throughout.
- ResetN pulsed low during SETTLE -> immediately IDLE, InReady=1, OutValid=0. A following add of 1+1 -> Result=2.
